// File: rtl/combination_cost_selector.sv
// Lowest-cost triple selector: scans a latched combination list one entry per
// clock, scores each legal (i,j,k) through a per-index weight table and keeps
// the cheapest, with earlier positions winning ties.
module combination_cost_selector #(
    parameter int MAX_COMBS = 39,
    parameter int MAX_IDX   = 7,
    parameter int IDX_W     = 3,
    parameter int COST_W    = 8,
    parameter int POS_W     = 6
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic [MAX_COMBS*3*IDX_W-1:0]     i_combo_list,
    input  logic [POS_W-1:0]                 i_num_combs,
    input  logic [(MAX_IDX+1)*COST_W-1:0]    i_weight_table,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_found,
    output logic [IDX_W-1:0]                 o_best_i,
    output logic [IDX_W-1:0]                 o_best_j,
    output logic [IDX_W-1:0]                 o_best_k,
    output logic [POS_W-1:0]                 o_best_pos,
    output logic [COST_W+1:0]                o_best_cost
);
    localparam int ENTRY_W = 3 * IDX_W;
    localparam int CW      = COST_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t                          r_state, w_next;
    logic [MAX_COMBS*ENTRY_W-1:0]    r_list;
    logic [(MAX_IDX+1)*COST_W-1:0]   r_wt;
    logic [POS_W-1:0]                r_n;
    logic [POS_W-1:0]                r_ptr;
    logic                            r_found;
    logic [IDX_W-1:0]                r_bi, r_bj, r_bk;
    logic [POS_W-1:0]                r_bpos;
    logic [CW-1:0]                   r_bcost;

    logic [ENTRY_W-1:0]              w_entry;
    logic [IDX_W-1:0]                w_idx [3];
    logic [IDX_W-1:0]                w_sel [3];
    logic [COST_W-1:0]               w_wt  [3];
    logic [2:0]                      w_ok;
    logic                            w_legal;
    logic [CW-1:0]                   w_cost;
    logic                            w_better;
    logic                            w_last;
    logic [POS_W-1:0]                w_n_clamp;

    assign w_entry = r_list[r_ptr*ENTRY_W +: ENTRY_W];

    // Per-field decode: zero or out-of-range indices are illegal and are
    // redirected to table slot 0 so the weight lookup always stays in range.
    for (genvar f = 0; f < 3; f++) begin : g_field
        assign w_idx[f] = w_entry[f*IDX_W +: IDX_W];
        assign w_ok[f]  = (w_idx[f] != '0) &&
                          ({1'b0, w_idx[f]} <= (IDX_W+1)'(MAX_IDX));
        assign w_sel[f] = w_ok[f] ? w_idx[f] : '0;
        assign w_wt[f]  = r_wt[w_sel[f]*COST_W +: COST_W];
    end

    assign w_legal   = &w_ok;
    assign w_cost    = CW'(w_wt[0]) + CW'(w_wt[1]) + CW'(w_wt[2]);
    // Strict less-than keeps the earliest entry on equal cost.
    assign w_better  = w_legal && (!r_found || (w_cost < r_bcost));
    assign w_last    = (r_ptr == r_n - 1'b1);
    assign w_n_clamp = (i_num_combs > POS_W'(MAX_COMBS)) ? POS_W'(MAX_COMBS)
                                                         : i_num_combs;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic: empty lists go straight to DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = (w_n_clamp != '0) ? S_SCAN : S_DONE;
            S_SCAN:  if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: latch inputs on accepted start, then score one entry per cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_list  <= '0;
            r_wt    <= '0;
            r_n     <= '0;
            r_ptr   <= '0;
            r_found <= 1'b0;
            r_bi    <= '0;
            r_bj    <= '0;
            r_bk    <= '0;
            r_bpos  <= '0;
            r_bcost <= '1;
        end else if (r_state == S_IDLE && i_start) begin
            r_list  <= i_combo_list;
            r_wt    <= i_weight_table;
            r_n     <= w_n_clamp;
            r_ptr   <= '0;
            r_found <= 1'b0;
            r_bi    <= '0;
            r_bj    <= '0;
            r_bk    <= '0;
            r_bpos  <= '0;
            r_bcost <= '1;
        end else if (r_state == S_SCAN) begin
            // Wrap the pointer on the last entry so it never indexes past the list.
            r_ptr <= w_last ? '0 : r_ptr + 1'b1;
            if (w_better) begin
                r_found <= 1'b1;
                r_bi    <= w_idx[0];
                r_bj    <= w_idx[1];
                r_bk    <= w_idx[2];
                r_bpos  <= r_ptr;
                r_bcost <= w_cost;
            end
        end
    end

    assign o_busy      = (r_state == S_SCAN);
    assign o_done      = (r_state == S_DONE);
    assign o_found     = r_found;
    assign o_best_i    = r_bi;
    assign o_best_j    = r_bj;
    assign o_best_k    = r_bk;
    assign o_best_pos  = r_bpos;
    assign o_best_cost = r_bcost;
endmodule

// File: tb/tb_combination_cost_selector.sv
// Directed bench for combination_cost_selector: hand-computed vectors,
// immediate assertions at each check point.
module tb_combination_cost_selector;
    localparam int MAX_COMBS = 39;
    localparam int MAX_IDX   = 7;
    localparam int IDX_W     = 3;
    localparam int COST_W    = 8;
    localparam int POS_W     = 6;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          start;
    logic [MAX_COMBS*3*IDX_W-1:0]  combo_list;
    logic [POS_W-1:0]              num_combs;
    logic [(MAX_IDX+1)*COST_W-1:0] weight_table;
    logic                          busy, done, found;
    logic [IDX_W-1:0]              best_i, best_j, best_k;
    logic [POS_W-1:0]              best_pos;
    logic [COST_W+1:0]             best_cost;

    int n_cmp = 0;
    int n_err = 0;

    combination_cost_selector #(
        .MAX_COMBS(MAX_COMBS), .MAX_IDX(MAX_IDX), .IDX_W(IDX_W),
        .COST_W(COST_W), .POS_W(POS_W)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_combo_list(combo_list), .i_num_combs(num_combs),
        .i_weight_table(weight_table),
        .o_busy(busy), .o_done(done), .o_found(found),
        .o_best_i(best_i), .o_best_j(best_j), .o_best_k(best_k),
        .o_best_pos(best_pos), .o_best_cost(best_cost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic f, input int i, input int j,
                           input int k, input int pos, input int cost);
        chk({tag, ".found"}, 32'(found), 32'(f));
        chk({tag, ".i"},     32'(best_i), 32'(i));
        chk({tag, ".j"},     32'(best_j), 32'(j));
        chk({tag, ".k"},     32'(best_k), 32'(k));
        chk({tag, ".pos"},   32'(best_pos), 32'(pos));
        chk({tag, ".cost"},  32'(best_cost), 32'(cost));
    endtask

    task automatic set_entry(input int m, input int i, input int j, input int k);
        combo_list[(m*3+0)*IDX_W +: IDX_W] = IDX_W'(i);
        combo_list[(m*3+1)*IDX_W +: IDX_W] = IDX_W'(j);
        combo_list[(m*3+2)*IDX_W +: IDX_W] = IDX_W'(k);
    endtask

    task automatic set_wt(input int n, input int w);
        weight_table[n*COST_W +: COST_W] = COST_W'(w);
    endtask

    // Pulse start across one rising edge (E0); returns just after E0.
    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles after E0 until done, and busy cycles on the way.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        int bc;
        lat = 0;
        bc  = 0;
        @(negedge clk);
        while (!done && lat < 60) begin
            bc += int'(busy);
            lat++;
            @(negedge clk);
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".busy_cycles"}, 32'(bc), 32'(exp_lat));
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dn;
        int first;

        rst = 1'b1;
        start = 1'b0;
        combo_list = '0;
        num_combs = '0;
        weight_table = '0;
        set_wt(1, 5); set_wt(2, 3); set_wt(3, 9); set_wt(4, 1);
        set_wt(5, 4); set_wt(6, 8); set_wt(7, 2);
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk_res("rst", 1'b0, 0, 0, 0, 0, 1023);
        rst = 1'b0;

        // Basic scan: costs 17, 9, 17 -> entry 1 wins.
        combo_list = '0;
        set_entry(0, 1, 2, 3); set_entry(1, 2, 2, 2); set_entry(2, 3, 2, 1);
        num_combs = 6'd3;
        do_start();
        wait_done("t1", 3);
        chk_res("t1", 1'b1, 2, 2, 2, 1, 9);
        @(negedge clk);
        chk("t1.done_pulse", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        chk("t1.hold_cost", 32'(best_cost), 32'd9);

        // Tie at cost 11: lower position kept.
        combo_list = '0;
        set_entry(0, 1, 4, 1); set_entry(1, 4, 1, 1);
        num_combs = 6'd2;
        do_start();
        wait_done("t2", 2);
        chk_res("t2", 1'b1, 1, 4, 1, 0, 11);

        // Empty list: done right after E0, previous result cleared.
        num_combs = 6'd0;
        do_start();
        wait_done("t3", 0);
        chk_res("t3", 1'b0, 0, 0, 0, 0, 1023);

        // Illegal entries skipped.
        combo_list = '0;
        set_entry(0, 0, 0, 0); set_entry(1, 7, 7, 7); set_entry(2, 7, 7, 0);
        num_combs = 6'd3;
        do_start();
        wait_done("t4", 3);
        chk_res("t4", 1'b1, 7, 7, 7, 1, 6);

        // Count clamped to the list depth.
        for (int m = 0; m < MAX_COMBS; m++) set_entry(m, 1, 1, 1);
        num_combs = 6'd50;
        do_start();
        wait_done("t5", 39);
        chk_res("t5", 1'b1, 1, 1, 1, 0, 15);

        // Start during SCAN and DONE ignored; input change after E0 ignored.
        combo_list = '0;
        set_entry(0, 1, 2, 3); set_entry(1, 2, 2, 2); set_entry(2, 3, 2, 1);
        num_combs = 6'd3;
        do_start();
        dn = 0;
        first = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                if (first < 0) first = c;
            end
            if (c == 0) begin
                start = 1'b1;
                set_entry(0, 4, 4, 4);
            end
            if (c == 1) start = 1'b0;
            if (c == 3) start = 1'b1;
            if (c == 4) start = 1'b0;
        end
        chk("t6.done_count", 32'(dn), 32'd1);
        chk("t6.done_cycle", 32'(first), 32'd3);
        chk("t6.busy_after", 32'(busy), 32'd0);
        chk_res("t6", 1'b1, 2, 2, 2, 1, 9);

        // Reset during scan cycle 2: immediate reset values, no done.
        combo_list = '0;
        set_entry(0, 1, 2, 3); set_entry(1, 2, 2, 2); set_entry(2, 3, 2, 1);
        do_start();
        @(negedge clk);
        chk("t7.busy_c1", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t7.busy", 32'(busy), 32'd0);
        chk("t7.done", 32'(done), 32'd0);
        chk_res("t7", 1'b0, 0, 0, 0, 0, 1023);
        @(negedge clk) rst = 1'b0;
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            dn += int'(done) + int'(busy);
        end
        chk("t7.no_done", 32'(dn), 32'd0);

        // Normal scan after mid-scan reset.
        combo_list = '0;
        set_entry(0, 1, 4, 1); set_entry(1, 4, 1, 1);
        num_combs = 6'd2;
        do_start();
        wait_done("t8", 2);
        chk_res("t8", 1'b1, 1, 4, 1, 0, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
